// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared width default, ALU mode codes and arbiter state encoding
package alu_arbiter_pkg;
  localparam int DATA_W_DEF = 16;
  localparam logic [2:0] MODE_ADD = 3'd0;
  localparam logic [2:0] MODE_SUB = 3'd1;
  localparam logic [2:0] MODE_AND = 3'd2;
  localparam logic [2:0] MODE_OR  = 3'd3;
  localparam logic [2:0] MODE_XOR = 3'd4;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// alu_arbiter_rr_pick: rotate-priority picker, first set req at or above ptr with wrap-around
module alu_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o
);
  logic [IW:0] pos;
  always_comb begin
    idx_o = '0;
    pos = '0;
    // scan farthest-first so the requester closest to ptr overwrites the choice last
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_i} + (IW+1)'(k);
      pos = pos >= (IW+1)'(NREQ) ? pos - (IW+1)'(NREQ) : pos;
      if (req_i[pos[IW-1:0]]) idx_o = pos[IW-1:0];
    end
    onehot_o = |req_i ? NREQ'(1) << idx_o : '0;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one external ALU between NREQ requesters
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREQ = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ*DATA_W-1:0] op_a_i,
  input  logic [NREQ*DATA_W-1:0] op_b_i,
  input  logic [NREQ*3-1:0]      mode_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic [NREQ-1:0]        done_o,
  output logic [DATA_W-1:0]      result_o,
  output logic                   busy_o,
  output logic [DATA_W-1:0]      alu_in1_o,
  output logic [DATA_W-1:0]      alu_in2_o,
  output logic [2:0]             alu_mode_o,
  input  logic [DATA_W-1:0]      alu_out_i
);
  localparam int IW = idx_w(NREQ);
  localparam int CW = idx_w(ALU_LAT + 1);
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, win_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d, win_oh;
  logic [DATA_W-1:0] result_q, result_d, in1_q, in1_d, in2_q, in2_d;
  logic [2:0] mode_q, mode_d;
  alu_arbiter_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i(req_i),
    .ptr_i(ptr_q),
    .onehot_o(win_oh),
    .idx_o(win_idx)
  );
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = |req_i ? S_WAIT : S_IDLE;
      S_WAIT:  state_d = cnt_q == '0 ? S_DONE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    ptr_d = ptr_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    gnt_d = gnt_q;
    done_d = done_q;
    result_d = result_q;
    in1_d = in1_q;
    in2_d = in2_q;
    mode_d = mode_q;
    case (state_q)
      S_IDLE: if (|req_i) begin
        idx_d = win_idx;
        gnt_d = win_oh;
        cnt_d = CW'(ALU_LAT);
        in1_d = op_a_i[win_idx*DATA_W +: DATA_W];
        in2_d = op_b_i[win_idx*DATA_W +: DATA_W];
        mode_d = mode_i[win_idx*3 +: 3];
      end
      S_WAIT: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      else begin
        result_d = alu_out_i;
        done_d = gnt_q;
      end
      S_DONE: begin
        done_d = '0;
        gnt_d = '0;
        in1_d = '0;
        in2_d = '0;
        mode_d = '0;
        ptr_d = idx_q == IW'(NREQ - 1) ? '0 : idx_q + IW'(1);
      end
      default: begin
        ptr_d = '0;
        idx_d = '0;
        cnt_d = '0;
        gnt_d = '0;
        done_d = '0;
        result_d = '0;
        in1_d = '0;
        in2_d = '0;
        mode_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      gnt_q <= '0;
      done_q <= '0;
      result_q <= '0;
      in1_q <= '0;
      in2_q <= '0;
      mode_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      result_q <= result_d;
      in1_q <= in1_d;
      in2_q <= in2_d;
      mode_q <= mode_d;
    end
  end
  assign gnt_o = gnt_q;
  assign done_o = done_q;
  assign result_o = result_q;
  assign busy_o = state_q != S_IDLE;
  assign alu_in1_o = in1_q;
  assign alu_in2_o = in2_q;
  assign alu_mode_o = mode_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized checks of the arbiter against a transaction-level round-robin model
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;
  localparam int DW = 16;
  localparam int NR = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NR-1:0] req = '0, gnt, done;
  logic [NR*DW-1:0] op_a = '0, op_b = '0;
  logic [NR*3-1:0] mode = '0;
  logic [DW-1:0] result, in1, in2, alu_out;
  logic [2:0] amode;
  logic busy;
  logic [NR-1:0] req3 = '0, gnt3, done3;
  logic [NR*DW-1:0] op_a3 = '0, op_b3 = '0;
  logic [NR*3-1:0] mode3 = '0;
  logic [DW-1:0] result3, in1_3, in2_3, alu_out3;
  logic [2:0] amode3;
  logic busy3;
  logic [DW-1:0] pipe3 [3];
  int compared = 0;
  int mismatched = 0;
  int mptr = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .NREQ(NR), .ALU_LAT(1)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .op_a_i(op_a), .op_b_i(op_b), .mode_i(mode),
    .gnt_o(gnt), .done_o(done), .result_o(result), .busy_o(busy),
    .alu_in1_o(in1), .alu_in2_o(in2), .alu_mode_o(amode), .alu_out_i(alu_out)
  );
  alu_arbiter #(.DATA_W(DW), .NREQ(NR), .ALU_LAT(3)) dut3 (
    .clk_i(clk), .reset_i(reset), .req_i(req3), .op_a_i(op_a3), .op_b_i(op_b3), .mode_i(mode3),
    .gnt_o(gnt3), .done_o(done3), .result_o(result3), .busy_o(busy3),
    .alu_in1_o(in1_3), .alu_in2_o(in2_3), .alu_mode_o(amode3), .alu_out_i(alu_out3)
  );

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] m);
    case (m)
      MODE_ADD: return a + b;
      MODE_SUB: return a - b;
      MODE_AND: return a & b;
      MODE_OR:  return a | b;
      MODE_XOR: return a ^ b;
      default:  return a;
    endcase
  endfunction

  function automatic int rr_win(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++) if (r[(p + k) % NR]) return (p + k) % NR;
    return 0;
  endfunction

  always @(posedge clk) begin
    alu_out <= alu_f(in1, in2, amode);
    pipe3[0] <= alu_f(in1_3, in2_3, amode3);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign alu_out3 = pipe3[2];

  task automatic observe(output logic [NR-1:0] g, output logic [DW-1:0] i1, output logic [DW-1:0] i2,
                         output logic [2:0] m, output logic bs, output logic [NR-1:0] d,
                         output logic [DW-1:0] res, output int lat, output bit to);
    int c = 0;
    to = 1'b0; g = '0; i1 = '0; i2 = '0; m = '0; bs = 1'b0; d = '0; res = '0; lat = 0;
    while (gnt == '0 && c < 20) begin @(negedge clk); c++; end
    if (gnt == '0) begin to = 1'b1; return; end
    g = gnt; i1 = in1; i2 = in2; m = amode; bs = busy;
    while (done == '0 && lat < 20) begin @(negedge clk); lat++; end
    d = done; res = result; to = done == '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    compared++; if ({gnt, done} !== '0) begin mismatched++; $display("FAIL reset_gnt_done: got %b want 0", {gnt, done}); end
    compared++; if (result !== '0) begin mismatched++; $display("FAIL reset_result: got %h want 0", result); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if ({in1, in2, amode} !== '0) begin mismatched++; $display("FAIL reset_alu_in: got %h want 0", {in1, in2, amode}); end
    compared++; if ({gnt3, done3, result3, busy3, in1_3, in2_3, amode3} !== '0) begin mismatched++; $display("FAIL reset_dut3: got %h want 0", {gnt3, done3, result3, busy3, in1_3, in2_3, amode3}); end
    @(negedge clk);
    reset = 1'b0;
    mptr = 0;
  endtask

  task automatic test_single;
    logic [NR-1:0] g, d; logic [DW-1:0] i1, i2, res; logic [2:0] m; logic bs; int lat; bit to;
    op_a[0 +: DW] = 16'd5; op_b[0 +: DW] = 16'd7; mode[0 +: 3] = MODE_ADD; req = 4'b0001;
    observe(g, i1, i2, m, bs, d, res, lat, to);
    compared++; if (to) begin mismatched++; $display("FAIL single_timeout: got timeout want done"); end
    compared++; if (g !== 4'b0001) begin mismatched++; $display("FAIL single_gnt: got %b want 0001", g); end
    compared++; if (i1 !== 16'd5 || i2 !== 16'd7 || m !== MODE_ADD) begin mismatched++; $display("FAIL single_alu_in: got %h %h %h want 0005 0007 0", i1, i2, m); end
    compared++; if (bs !== 1'b1) begin mismatched++; $display("FAIL single_busy: got %b want 1", bs); end
    compared++; if (lat !== 2) begin mismatched++; $display("FAIL single_latency: got %0d want 2", lat); end
    compared++; if (d !== 4'b0001) begin mismatched++; $display("FAIL single_done: got %b want 0001", d); end
    compared++; if (res !== 16'd12) begin mismatched++; $display("FAIL single_result: got %h want 000c", res); end
    req = '0;
    mptr = 1;
    @(negedge clk);
    compared++; if ({done, gnt, busy} !== '0) begin mismatched++; $display("FAIL single_after: got done %b gnt %b busy %b want 0", done, gnt, busy); end
    repeat (3) @(negedge clk);
    compared++; if (gnt !== '0 || result !== 16'd12) begin mismatched++; $display("FAIL single_no_regrant: got gnt %b result %h want 0 000c", gnt, result); end
  endtask

  task automatic test_all_at_once;
    logic [NR-1:0] g, d; logic [DW-1:0] i1, i2, res; logic [2:0] m; logic bs; int lat; bit to;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mptr = 0;
    for (int k = 0; k < NR; k++) begin
      op_a[k*DW +: DW] = DW'($urandom); op_b[k*DW +: DW] = DW'($urandom); mode[k*3 +: 3] = MODE_ADD;
    end
    req = 4'b1111;
    for (int k = 0; k < NR; k++) begin
      observe(g, i1, i2, m, bs, d, res, lat, to);
      compared++; if (g !== NR'(1) << k) begin mismatched++; $display("FAIL all_order%0d: got %b want %b", k, g, NR'(1) << k); end
      compared++; if (d !== NR'(1) << k || lat !== 2) begin mismatched++; $display("FAIL all_done%0d: got %b lat %0d want %b lat 2", k, d, lat, NR'(1) << k); end
      compared++; if (res !== op_a[k*DW +: DW] + op_b[k*DW +: DW]) begin mismatched++; $display("FAIL all_result%0d: got %h want %h", k, res, op_a[k*DW +: DW] + op_b[k*DW +: DW]); end
      req[k] = 1'b0;
      mptr = (k + 1) % NR;
      @(negedge clk);
    end
  endtask

  task automatic test_fairness;
    logic [NR-1:0] g, d, prev; logic [DW-1:0] i1, i2, res; logic [2:0] m; logic bs; int lat, w; bit to;
    int seq [4] = '{0, 2, 0, 2};
    prev = '0;
    req = 4'b0101;
    for (int t = 0; t < 4; t++) begin
      w = rr_win(req, mptr);
      observe(g, i1, i2, m, bs, d, res, lat, to);
      compared++; if (g !== NR'(1) << seq[t] || g !== NR'(1) << w) begin mismatched++; $display("FAIL fair_gnt%0d: got %b want %b", t, g, NR'(1) << seq[t]); end
      compared++; if (g === prev) begin mismatched++; $display("FAIL fair_repeat%0d: got %b twice want alternation", t, g); end
      prev = g;
      req[w] = 1'b0;
      mptr = (w + 1) % NR;
      @(negedge clk);
      req[w] = 1'b1;
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_wrap;
    logic [NR-1:0] g, d; logic [DW-1:0] i1, i2, res; logic [2:0] m; logic bs; int lat; bit to;
    op_a[DW +: DW] = 16'hFFFF; op_b[DW +: DW] = 16'h0001; mode[3 +: 3] = MODE_ADD; req = 4'b0010;
    observe(g, i1, i2, m, bs, d, res, lat, to);
    compared++; if (g !== 4'b0010 || d !== 4'b0010) begin mismatched++; $display("FAIL wrap_gnt: got gnt %b done %b want 0010", g, d); end
    compared++; if (i1 !== 16'hFFFF || i2 !== 16'h0001) begin mismatched++; $display("FAIL wrap_alu_in: got %h %h want ffff 0001", i1, i2); end
    compared++; if (res !== 16'h0000) begin mismatched++; $display("FAIL wrap_result: got %h want 0000", res); end
    req = '0;
    mptr = 2;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [NR-1:0] g, d; logic [DW-1:0] i1, i2, res; logic [2:0] m; logic bs; int lat, c, w; bit to;
    op_a[0 +: 2*DW] = {DW'($urandom), DW'($urandom)}; op_b[0 +: 2*DW] = {DW'($urandom), DW'($urandom)};
    mode[0 +: 6] = {MODE_XOR, MODE_SUB};
    req = 4'b0011;
    w = rr_win(req, mptr);
    c = 0;
    while (gnt == '0 && c < 20) begin @(negedge clk); c++; end
    compared++; if (gnt !== NR'(1) << w) begin mismatched++; $display("FAIL rmid_gnt: got %b want %b", gnt, NR'(1) << w); end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    compared++; if ({gnt, done, busy, in1, in2, amode, result} !== '0) begin mismatched++; $display("FAIL rmid_async_clear: got %h want 0", {gnt, done, busy, in1, in2, amode, result}); end
    @(negedge clk);
    compared++; if (done !== '0) begin mismatched++; $display("FAIL rmid_no_done: got %b want 0", done); end
    reset = 1'b0;
    mptr = 0;
    observe(g, i1, i2, m, bs, d, res, lat, to);
    compared++; if (g !== 4'b0001 || d !== 4'b0001 || to) begin mismatched++; $display("FAIL rmid_reserve: got gnt %b done %b want 0001", g, d); end
    compared++; if (res !== op_a[0 +: DW] - op_b[0 +: DW]) begin mismatched++; $display("FAIL rmid_result: got %h want %h", res, op_a[0 +: DW] - op_b[0 +: DW]); end
    req = '0;
    mptr = 1;
    @(negedge clk);
  endtask

  task automatic test_latency;
    logic [DW-1:0] a, b;
    int c, lat;
    a = DW'($urandom); b = DW'($urandom);
    op_a3[0 +: DW] = a; op_b3[0 +: DW] = b; mode3[0 +: 3] = MODE_ADD; req3 = 4'b0001;
    c = 0;
    while (gnt3 == '0 && c < 20) begin @(negedge clk); c++; end
    compared++; if (gnt3 !== 4'b0001 || in1_3 !== a || in2_3 !== b) begin mismatched++; $display("FAIL lat_grant: got %b %h %h want 0001 %h %h", gnt3, in1_3, in2_3, a, b); end
    @(negedge clk);
    req3 = '0; op_a3[0 +: DW] = ~a; op_b3[0 +: DW] = b ^ 16'h5A5A;
    lat = 1;
    while (done3 == '0 && lat < 20) begin @(negedge clk); lat++; end
    compared++; if (lat !== 4 || done3 !== 4'b0001) begin mismatched++; $display("FAIL lat_done: got lat %0d done %b want 4 0001", lat, done3); end
    compared++; if (result3 !== a + b) begin mismatched++; $display("FAIL lat_result: got %h want %h", result3, a + b); end
    @(negedge clk);
    compared++; if (done3 !== '0 || busy3 !== 1'b0 || in1_3 !== '0) begin mismatched++; $display("FAIL lat_return: got done %b busy %b in1 %h want 0", done3, busy3, in1_3); end
  endtask

  task automatic test_random;
    logic [NR-1:0] g, d; logic [DW-1:0] i1, i2, res, ea, eb; logic [2:0] m, em; logic bs; int lat, w; bit to;
    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < NR; k++) begin
        op_a[k*DW +: DW] = DW'($urandom); op_b[k*DW +: DW] = DW'($urandom); mode[k*3 +: 3] = 3'($urandom_range(0, 4));
      end
      req = NR'($urandom_range(1, 15));
      w = rr_win(req, mptr);
      ea = op_a[w*DW +: DW]; eb = op_b[w*DW +: DW]; em = mode[w*3 +: 3];
      observe(g, i1, i2, m, bs, d, res, lat, to);
      compared++; if (g !== NR'(1) << w || d !== NR'(1) << w) begin mismatched++; $display("FAIL rand%0d_gnt: got gnt %b done %b want %b", t, g, d, NR'(1) << w); end
      compared++; if (i1 !== ea || i2 !== eb || m !== em) begin mismatched++; $display("FAIL rand%0d_alu_in: got %h %h %h want %h %h %h", t, i1, i2, m, ea, eb, em); end
      compared++; if (res !== alu_f(ea, eb, em) || lat !== 2) begin mismatched++; $display("FAIL rand%0d_result: got %h lat %0d want %h lat 2", t, res, lat, alu_f(ea, eb, em)); end
      req = '0;
      mptr = (w + 1) % NR;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_at_once();
    test_fairness();
    test_wrap();
    test_reset_mid();
    test_latency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want summary before time limit");
    $fatal(1);
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single 16-bit ALU between NREQ requesters.
- Each requester presents two operands and an ALU mode.
- The block grants one requester at a time, drives the ALU inputs, waits the ALU's fixed latency, captures the result and pulses a per-requester done.
- It sits between the ALU and the operand-producing state machines; those state machines no longer drive the ALU directly.

## Interface
Parameters:
- DATA_W, 16, operand/result width
- NREQ, 4, number of requesters (2..8)
- ALU_LAT, 1, ALU input-to-output latency in clock edges (≥1)

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately
- req  input  NREQ  request per requester; level, held until done
- op_a  input  NREQ*DATA_W  operand 1; requester i at [i*DATA_W +: DATA_W]
- op_b  input  NREQ*DATA_W  operand 2, same packing
- mode  input  NREQ*3  ALU mode; requester i at [i*3 +: 3]
- gnt  output  NREQ  one-hot grant, high from grant edge through DONE
- done  output  NREQ  one-cycle pulse to the served requester
- result  output  DATA_W  last captured ALU result; held until next capture
- busy  output  1  high whenever state ≠ IDLE
- alu_in1  output  DATA_W  registered ALU operand 1
- alu_in2  output  DATA_W  registered ALU operand 2
- alu_mode  output  3  registered ALU mode
- alu_out  input  DATA_W  ALU result

## Operation
- **Reset values:** every output is 0; state = IDLE; rr pointer = 0; wait counter = 0.
- **States:** IDLE, WAIT, DONE (2-bit encoding, unused code → IDLE, all outputs cleared).
- **IDLE:**
  - If req is zero, stay in IDLE.
  - Otherwise pick the winner: the first set bit searching from the rr pointer upward, wrapping modulo NREQ.
  - On the edge: latch the winner's op_a/op_b/mode into alu_in1/alu_in2/alu_mode, set gnt to the one-hot winner, load the counter with ALU_LAT, go to WAIT.
- **WAIT:**
  - While counter ≠ 0: decrement by 1.
  - When counter = 0: result ← alu_out, done ← gnt, go to DONE.
- **DONE:**
  - Clear done, gnt, alu_in1, alu_in2 and alu_mode.
  - Set the rr pointer to (winner+1) mod NREQ.
  - Go to IDLE.
- **Operand stability:** operands and mode are sampled only at the grant edge. Later changes on the requester inputs have no effect on the transaction in flight.
- **req dropped mid-transaction:** the transaction completes; done still pulses; result is updated.
- **Arithmetic:** operands pass through unmodified. result is alu_out verbatim, with no sign handling or extension, and wraps at DATA_W as the ALU produces it.
- **Reset mid-operation:** the transaction is discarded, no done is issued, the pointer returns to 0, and the requester must keep req asserted to be re-served.

## Timing
- Grant edge G (IDLE, req≠0) → ALU inputs valid after G.
- The capture edge is G+ALU_LAT+1. done and the new result are visible after that edge; done is high for exactly one cycle.
- The block returns to IDLE at G+ALU_LAT+2. The next grant is no earlier than G+ALU_LAT+3, so the cycle per transaction is ALU_LAT+3 edges (4 for ALU_LAT=1).
- A requester that drops req on the edge after seeing done is not re-granted.
- Simultaneous requests: exactly one grant per transaction. After winner w, the next search starts at w+1.
- A requester waits at most NREQ−1 transactions.

## Structure
- Shared include alu_defs.vh holds:
  - DATA_W default
  - ALU mode codes (MODE_ADD = 3'd0, …)
  - arbiter state encodings
- Sub-module rr_pick: combinational rotate-priority picker.
  - Inputs: req, ptr. Outputs: one-hot winner and its index.
  - Instantiated once.
- The ALU is instantiated outside this block and connected through the alu_* ports.

## Test plan
All scenarios use the real ALU (1-cycle registered adder in MODE_ADD) unless stated.
- **Single request:** req0 with a=5, b=7, mode 0 → gnt=0001 after G; done=0001 for one cycle after G+2; result=12; busy low after G+3.
- **All requests at once:** req=1111 after reset with distinct operands → served in order 0,1,2,3; each done pulses once with the correct sum.
- **Fairness:** req0 and req2 held high, each requester dropping its req for one cycle after its done → grant sequence 0,2,0,2; requester 0 is never served twice in a row.
- **Reset mid-operation:** reset asserted in WAIT → all outputs 0 immediately without a clock; no done. After release, a held req0 is re-served with the correct result.
- **Latency and mid-transaction changes:** ALU_LAT=3 with a stub ALU delaying 3 edges; req dropped and op_a changed during WAIT → done after G+4 with the result of the originally latched operands.
- **Wrap-around:** a=0xFFFF, b=0x0001, MODE_ADD → result=0x0000; alu_in1/alu_in2 equal 0xFFFF/0x0001 exactly.
